// File: rtl/breathled_multi_if.sv
// Control/status bundle for the multi-channel breathing LED driver.
// The controller side (master) drives run/mode/duty; the driver (slave) returns LEDs, levels and tick.
interface breathled_multi_if #(
    parameter int CH    = 4,
    parameter int PWM_W = 8
);
    logic                  en;
    logic                  mode;
    logic [PWM_W-1:0]      duty_in;
    logic [CH-1:0]         led;
    logic [CH*PWM_W-1:0]   level_flat;
    logic                  period_tick;

    modport master (
        output en, mode, duty_in,
        input  led, level_flat, period_tick
    );

    modport slave (
        input  en, mode, duty_in,
        output led, level_flat, period_tick
    );
endinterface

// File: rtl/breathled_multi.sv
// CH-channel breathing LED driver: one shared PWM period counter, per-channel triangular level ramps
// with a phase offset, and a fixed-duty mode. Optional macro GAMMA_EN adds a square-law duty curve.
module breathled_multi #(
    parameter int CH       = 4,
    parameter int PWM_W    = 8,
    parameter int STEP_DIV = 14000,
    parameter int DIV_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    breathled_multi_if.slave bus
);
    localparam logic [PWM_W-1:0] MAX       = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] LAST      = MAX - PWM_W'(1);
    localparam logic [DIV_W-1:0] STEP_LAST = DIV_W'(STEP_DIV - 1);

    // Spread the start levels evenly over 0..MAX so the channels breathe as a wave.
    function automatic logic [PWM_W-1:0] init_level(input int k);
        int prod;
        prod = (k * ((2 ** PWM_W) - 1)) / CH;
        return prod[PWM_W-1:0];
    endfunction

    logic [PWM_W-1:0]            pwm_cnt_reg;
    logic [DIV_W-1:0]            step_cnt_reg;
    logic [CH-1:0]               led_reg;
    logic                        tick_reg;
    logic [PWM_W-1:0]            level_reg [CH];
    logic                        dir_reg   [CH];   // 1 = ramping up
    logic [CH-1:0][PWM_W-1:0]    eff;
    logic [CH-1:0]               led_next;
    logic                        wrap;

    assign wrap = bus.en && (pwm_cnt_reg == LAST);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
`ifdef GAMMA_EN
            logic [2*PWM_W-1:0] sq;
            assign sq      = ({{PWM_W{1'b0}}, level_reg[gi]} * {{PWM_W{1'b0}}, level_reg[gi]})
                           + {{PWM_W{1'b0}}, MAX};
            assign eff[gi] = sq[2*PWM_W-1:PWM_W];
`else
            assign eff[gi] = level_reg[gi];
`endif
            assign led_next[gi] = bus.en & (pwm_cnt_reg < eff[gi]);
            assign bus.level_flat[gi*PWM_W +: PWM_W] = level_reg[gi];
        end
    endgenerate

    assign bus.led         = led_reg;
    assign bus.period_tick = tick_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_reg  <= '0;
            step_cnt_reg <= '0;
            led_reg      <= '0;
            tick_reg     <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                level_reg[k] <= init_level(k);
                dir_reg[k]   <= 1'b1;
            end
        end else begin
            tick_reg <= wrap;
            led_reg  <= led_next;
            if (bus.en) begin
                pwm_cnt_reg <= wrap ? '0 : pwm_cnt_reg + PWM_W'(1);
            end
            // Levels only move at the period boundary so a PWM period never sees two duty values.
            if (wrap) begin
                if (bus.mode) begin
                    step_cnt_reg <= '0;
                    for (int k = 0; k < CH; k++) begin
                        level_reg[k] <= bus.duty_in;
                    end
                end else if (step_cnt_reg == STEP_LAST) begin
                    step_cnt_reg <= '0;
                    for (int k = 0; k < CH; k++) begin
                        if (dir_reg[k]) begin
                            if (level_reg[k] == MAX) begin
                                dir_reg[k]   <= 1'b0;
                                level_reg[k] <= MAX - PWM_W'(1);
                            end else begin
                                level_reg[k] <= level_reg[k] + PWM_W'(1);
                            end
                        end else begin
                            if (level_reg[k] == '0) begin
                                dir_reg[k]   <= 1'b1;
                                level_reg[k] <= PWM_W'(1);
                            end else begin
                                level_reg[k] <= level_reg[k] - PWM_W'(1);
                            end
                        end
                    end
                end else begin
                    step_cnt_reg <= step_cnt_reg + DIV_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/breathled_multi.md
Name: breathled_multi

Overview:
- Parametrised successor of the single-channel breathing LED driver.
- Drives CH LED outputs from one shared PWM period counter.
- Each channel has its own duty level. Levels ramp up/down triangularly, with a fixed phase offset per channel so the LEDs breathe in a wave.
- A fixed-duty mode lets firmware pin all channels to a common level; sits between the board clock and the LED pins.

Parameters:
- CH, 4: number of LED channels (1..16).
- PWM_W, 8: duty level width. MAX = 2^PWM_W-1; PWM period = MAX clocks.
- STEP_DIV, 14000: PWM periods per level step in breathe mode (>=1).
- DIV_W, 20: prescaler width; must hold STEP_DIV-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  1 = run; 0 = freeze counters and force LEDs off.
- mode  input  1  0 = breathe, 1 = fixed duty.
- duty_in  input  PWM_W  common duty used in fixed mode.
- led  output  CH  registered PWM outputs, bit k = channel k.
- level_flat  output  CH*PWM_W  current levels, channel k at bits [k*PWM_W +: PWM_W].
- period_tick  output  1  one-cycle pulse on the cycle pwm_cnt wraps to 0.

Behaviour:
- Reset (async, any time, including mid-ramp):
  - pwm_cnt=0, step_cnt=0, led=0, period_tick=0.
  - level[k] = (k*MAX)/CH truncated; dir[k] = up for all channels.
  - Reset release resumes from this state on the next clock edge.
- pwm_cnt:
  - Counts 0..MAX-1 when en=1, then wraps to 0.
  - period_tick = 1 registered on the wrap cycle.
  - Holds while en=0.
- LED output (registered, one-cycle latency): led[k] <= en & (pwm_cnt < eff[k]).
  - eff[k] = level[k] without gamma.
  - Level 0 gives constant 0. Level MAX gives constant 1 while en=1.
  - Level L gives exactly L high clocks per MAX-clock period.
- Level updates happen only at the period wrap (pwm_cnt==MAX-1 and en=1), so there are no mid-period glitches.
- Breathe mode (mode=0):
  - step_cnt increments at each wrap. When step_cnt==STEP_DIV-1 at a wrap, it clears and every channel steps.
  - Up step: if level==MAX, dir<=down and level<=MAX-1; otherwise level+1.
  - Down step: if level==0, dir<=up and level<=1; otherwise level-1.
  - Channels step simultaneously; no value is held at the ends for an extra step.
- Fixed mode (mode=1):
  - At each wrap, all level[k] <= duty_in. step_cnt is cleared; dir is unchanged.
  - Changes to duty_in take effect at the next period start.
- Mode change 1->0: breathing resumes from the current (common) level with the retained dir per channel. The prescaler restarts from 0.
- en=0:
  - led=0 on the next clock.
  - pwm_cnt, step_cnt, level and dir all hold; period_tick=0.
  - en 0->1 resumes exactly where frozen.
- Simultaneous mode change and wrap: the mode value sampled at the wrap cycle governs that update.
- level_flat is a direct view of the level registers (no extra latency).

Optional Feature:
- Macro GAMMA_EN enables perceptual gamma correction.
- Defined: eff[k] = (level[k]*level[k] + MAX) >> PWM_W, a 2*PWM_W-bit product truncated to PWM_W bits. Maps 0->0, 1->1, MAX->MAX; for PWM_W=4, level 7 -> (49+15)>>4 = 4.
- Not defined: eff[k] = level[k] and no multiplier is instantiated.
- level_flat always reports the uncorrected level.

Test Plan:
- Bench setup: CH=4, PWM_W=4 (MAX=15), STEP_DIV=2, GAMMA_EN off unless stated.
- Reset: assert reset mid-run -> led=0 immediately, level_flat = {11,7,3,0} (ch3..ch0), period_tick=0. Release with en=1, mode=0 -> period_tick every 15 clocks.
- Duty shape: ch2 level 7 -> led[2] high for exactly 7 of 15 clocks, starting one clock after the wrap. Ch0 level 0 -> never high.
- Ramp/bounce: run 2 periods -> all levels +1 ({12,8,4,1}). Run until ch3 reaches 15 -> next step gives 14 and ch3 thereafter decreases; ch0 rising from 0 never repeats a value.
- Fixed mode: mode=1, duty_in=5 -> after next wrap all levels = 5 and every led high 5/15. Change duty_in to 15 mid-period -> applied at next wrap, LEDs constant high.
- Enable freeze: en=0 for 40 clocks -> led=0 within 1 clock, level_flat and phase unchanged. en=1 -> the next wrap comes after the same remaining count.
- GAMMA_EN defined: level 7 -> led high 4/15 clocks; level 15 -> constant high; level_flat still reports 7.
